// File: rtl/i_fetch_prefetch.sv
// Instruction-fetch initiator with a small prefetch FIFO feeding the decoder.
// Optional: define BF_IFETCH_STOP_ON_ZERO_EN to halt fetch after a 0x00 byte until redirect.
module i_fetch_prefetch #(
    parameter int unsigned i_addr_width = 16,
    parameter int unsigned fifo_depth   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    i_req,
    output logic [i_addr_width-1:0] i_addr,
    input  logic                    i_ack,
    input  logic [7:0]              i_rdata,
    output logic                    insn_valid,
    output logic [7:0]              insn,
    output logic [i_addr_width-1:0] insn_pc,
    input  logic                    insn_ready,
    input  logic                    redirect,
    input  logic [i_addr_width-1:0] redirect_pc
);

    localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned cnt_w = ptr_w + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t                  state;
    logic [i_addr_width-1:0] fetch_pc;
    logic [7:0]              byte_q [fifo_depth];
    logic [i_addr_width-1:0] pc_q   [fifo_depth];
    logic [ptr_w-1:0]        rd_ptr;
    logic [ptr_w-1:0]        wr_ptr;
    logic [cnt_w-1:0]        count;
    logic [cnt_w-1:0]        count_nxt;
    logic                    push;
    logic                    pop;
    logic                    slot_free;

    always_comb begin
        push      = (state == REQ) && i_ack;
        pop       = insn_valid && insn_ready;
        slot_free = count < cnt_w'(fifo_depth);
        count_nxt = count + cnt_w'(push) - cnt_w'(pop);
    end

    assign insn    = byte_q[rd_ptr];
    assign insn_pc = pc_q[rd_ptr];

    // Fetch FSM and FIFO bookkeeping; redirect outranks everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i_req      <= 1'b0;
            i_addr     <= '0;
            fetch_pc   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            insn_valid <= 1'b0;
        end else if (redirect) begin
            state      <= GAP;
            i_req      <= 1'b0;
            fetch_pc   <= redirect_pc;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            insn_valid <= 1'b0;
        end else begin
            count      <= count_nxt;
            insn_valid <= (count_nxt != '0);
            if (push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            case (state)
                IDLE: begin
                    if (slot_free) begin
                        state  <= REQ;
                        i_req  <= 1'b1;
                        i_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (i_ack) begin
                        i_req    <= 1'b0;
                        fetch_pc <= fetch_pc + i_addr_width'(1);
`ifdef BF_IFETCH_STOP_ON_ZERO_EN
                        state    <= (i_rdata == 8'h00) ? HALT : GAP;
`else
                        state    <= GAP;
`endif
                    end
                end
                GAP:     state <= IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Head storage needs no reset: insn_valid qualifies it.
    always_ff @(posedge clk) begin
        if (!rst && !redirect && push) begin
            byte_q[wr_ptr] <= i_rdata;
            pc_q[wr_ptr]   <= i_addr;
        end
    end

endmodule

// File: tb/tb_i_fetch_prefetch.sv
// Directed self-checking bench for i_fetch_prefetch with a behavioural instruction memory.
module tb_i_fetch_prefetch;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [7:0]  i_rdata;
    logic        insn_valid;
    logic [7:0]  insn;
    logic [15:0] insn_pc;
    logic        insn_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int tests;
    int fails;

    logic [7:0] mem [0:65535];
    int mem_lat;
    int wcnt;

    i_fetch_prefetch #(.i_addr_width(16), .fifo_depth(4)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc),
        .insn_ready(insn_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_lat waiting cycles, ack held until i_req drops.
    always @(negedge clk) begin
        if (!i_req) begin
            i_ack = 1'b0;
            wcnt  = 0;
        end else if (wcnt >= mem_lat) begin
            i_ack   = 1'b1;
            i_rdata = mem[i_addr];
        end else begin
            wcnt = wcnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        insn_ready = 1'b0;
        mem_lat = 1;
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        tests++; if (i_req !== 1'b0) begin fails++; $display("FAIL reset_i_req: got %b expected 0", i_req); end
        tests++; if (i_addr !== 16'h0000) begin fails++; $display("FAIL reset_i_addr: got %h expected 0000", i_addr); end
        tests++; if (insn_valid !== 1'b0) begin fails++; $display("FAIL reset_insn_valid: got %b expected 0", insn_valid); end
        rst = 1'b0;
    endtask

    task automatic test_in_order();
        int got;
        mem_lat = 1;
        insn_ready = 1'b1;
        do_reset();
        tick();
        tests++; if (i_req !== 1'b1 || i_addr !== 16'h0000) begin fails++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", i_req, i_addr); end
        tick();
        tests++; if (i_ack !== 1'b1 || insn_valid !== 1'b0) begin fails++; $display("FAIL ack_cycle: got ack=%b valid=%b expected ack=1 valid=0", i_ack, insn_valid); end
        tick();
        tests++; if (insn_valid !== 1'b1 || insn !== 8'h2B || insn_pc !== 16'h0000) begin fails++; $display("FAIL first_insn: got v=%b insn=%h pc=%h expected v=1 insn=2b pc=0000", insn_valid, insn, insn_pc); end
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (insn_valid) begin
                tests++; if (insn !== mem[got] || insn_pc !== 16'(got)) begin fails++; $display("FAIL order_%0d: got insn=%h pc=%h expected insn=%h pc=%h", got, insn, insn_pc, mem[got], 16'(got)); end
                got++;
            end
            tick();
        end
        tests++; if (got !== 4) begin fails++; $display("FAIL order_count: got %0d expected 4", got); end
    endtask

    task automatic test_backpressure();
        int reqs;
        logic prev;
        logic [15:0] addr_seen;
        mem_lat = 1;
        insn_ready = 1'b0;
        do_reset();
        reqs = 0; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (i_req && !prev) reqs++;
            prev = i_req;
        end
        tests++; if (reqs !== 4) begin fails++; $display("FAIL full_req_count: got %0d expected 4", reqs); end
        tests++; if (i_req !== 1'b0 || insn_pc !== 16'h0000) begin fails++; $display("FAIL full_idle: got req=%b pc=%h expected req=0 pc=0000", i_req, insn_pc); end
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        tests++; if (insn_pc !== 16'h0001) begin fails++; $display("FAIL pop_one_head: got %h expected 0001", insn_pc); end
        reqs = 0; prev = i_req; addr_seen = 16'hDEAD;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (i_req && !prev) begin reqs++; addr_seen = i_addr; end
            prev = i_req;
        end
        tests++; if (reqs !== 1 || addr_seen !== 16'h0004) begin fails++; $display("FAIL refill_req: got n=%0d addr=%h expected n=1 addr=0004", reqs, addr_seen); end
        tests++; if (insn_pc !== 16'h0001 || insn_valid !== 1'b1) begin fails++; $display("FAIL refill_head: got v=%b pc=%h expected v=1 pc=0001", insn_valid, insn_pc); end
    endtask

    task automatic test_slow_ack();
        int held;
        logic acked;
        mem_lat = 5;
        insn_ready = 1'b0;
        do_reset();
        held = 0; acked = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (i_ack) begin acked = 1'b1; break; end
            if (i_req) begin
                held++;
                tests++; if (i_addr !== 16'h0000) begin fails++; $display("FAIL slow_addr_hold: got %h expected 0000", i_addr); end
            end
        end
        tests++; if (acked !== 1'b1 || held !== 5) begin fails++; $display("FAIL slow_hold_len: got acked=%b held=%0d expected acked=1 held=5", acked, held); end
        tick();
        tests++; if (insn_valid !== 1'b1 || insn_pc !== 16'h0000 || i_req !== 1'b0) begin fails++; $display("FAIL slow_push: got v=%b pc=%h req=%b expected v=1 pc=0000 req=0", insn_valid, insn_pc, i_req); end
        for (int c = 0; c < 14; c++) tick();
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        tests++; if (insn_valid !== 1'b1 || insn_pc !== 16'h0001 || insn !== mem[1]) begin fails++; $display("FAIL slow_no_dup: got v=%b pc=%h insn=%h expected v=1 pc=0001 insn=%h", insn_valid, insn_pc, insn, mem[1]); end
        mem_lat = 1;
    endtask

    task automatic test_redirect();
        logic found;
        mem_lat = 1;
        insn_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (i_ack && i_addr == 16'h0001) begin found = 1'b1; break; end
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL redir_setup: got found=%b expected 1", found); end
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        tests++; if (insn_valid !== 1'b0 || i_req !== 1'b0) begin fails++; $display("FAIL redir_flush: got v=%b req=%b expected v=0 req=0", insn_valid, i_req); end
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (insn_valid) begin found = 1'b1; break; end
        end
        tests++; if (found !== 1'b1 || insn_pc !== 16'h0100 || insn !== mem[16'h0100]) begin fails++; $display("FAIL redir_target: got v=%b pc=%h insn=%h expected v=1 pc=0100 insn=%h", found, insn_pc, insn, mem[16'h0100]); end
    endtask

    task automatic test_wrap();
        int got;
        logic [15:0] ep;
        insn_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            tick();
            if (insn_valid) begin
                ep = 16'(32'hFFFE + got);
                tests++; if (insn_pc !== ep || insn !== mem[ep]) begin fails++; $display("FAIL wrap_%0d: got pc=%h insn=%h expected pc=%h insn=%h", got, insn_pc, insn, ep, mem[ep]); end
                got++;
            end
        end
        tests++; if (got !== 3) begin fails++; $display("FAIL wrap_count: got %0d expected 3", got); end
    endtask

    task automatic test_zero_byte();
        int got;
        int n;
        mem[2] = 8'h00;
        mem_lat = 1;
        insn_ready = 1'b1;
        do_reset();
`ifdef BF_IFETCH_STOP_ON_ZERO_EN
        n = 3;
`else
        n = 4;
`endif
        got = 0;
        for (int c = 0; c < 40 && got < n; c++) begin
            tick();
            if (insn_valid) begin
                tests++; if (insn_pc !== 16'(got) || insn !== mem[got]) begin fails++; $display("FAIL zero_seq_%0d: got pc=%h insn=%h expected pc=%h insn=%h", got, insn_pc, insn, 16'(got), mem[got]); end
                got++;
            end
        end
        tests++; if (got !== n) begin fails++; $display("FAIL zero_seq_count: got %0d expected %0d", got, n); end
`ifdef BF_IFETCH_STOP_ON_ZERO_EN
        begin
            int hi;
            logic seen;
            hi = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (i_req) hi++;
            end
            tests++; if (hi !== 0 || insn_valid !== 1'b0) begin fails++; $display("FAIL zero_halt: got req_cycles=%0d v=%b expected 0 0", hi, insn_valid); end
            redirect = 1'b1;
            redirect_pc = 16'h0010;
            tick();
            redirect = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (i_req) begin seen = 1'b1; break; end
            end
            tests++; if (seen !== 1'b1 || i_addr !== 16'h0010) begin fails++; $display("FAIL zero_resume: got seen=%b addr=%h expected 1 0010", seen, i_addr); end
        end
`endif
        mem[2] = 8'h3E;
    endtask

    task automatic test_reset_mid();
        logic seen;
        mem_lat = 5;
        insn_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (i_req) begin seen = 1'b1; break; end
        end
        tests++; if (seen !== 1'b1 || i_addr !== 16'h0040) begin fails++; $display("FAIL mid_setup: got seen=%b addr=%h expected 1 0040", seen, i_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (i_req !== 1'b0 || insn_valid !== 1'b0 || i_addr !== 16'h0000) begin fails++; $display("FAIL mid_reset: got req=%b v=%b addr=%h expected 0 0 0000", i_req, insn_valid, i_addr); end
        tick();
        tests++; if (i_req !== 1'b1 || i_addr !== 16'h0000) begin fails++; $display("FAIL mid_restart: got req=%b addr=%h expected 1 0000", i_req, i_addr); end
        mem_lat = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        wcnt = 0;
        i_ack = 1'b0;
        i_rdata = 8'h00;
        rst = 1'b1;
        insn_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        mem_lat = 1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'hA5;
        mem[0] = 8'h2B;
        mem[1] = 8'h2B;
        mem[2] = 8'h3E;
        mem[3] = 8'h2E;
        test_reset();
        test_in_order();
        test_backpressure();
        test_slow_ack();
        test_redirect();
        test_wrap();
        test_zero_byte();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
